dmem_bus_arbiter: RTL and testbench

Arbitrates the single data-memory port between two requesters: the core load/store unit (m0) and the debug/program loader (m1). It also decodes addresses above `IO_BASE` onto the write-only I/O port. It sits between `core`, `d_mem` and the I/O outputs in `top`. Arbitration is round-robin, with an optional per-master lock for atomic read-modify-write sequences and a lock timeout.

---
 rtl/dmem_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter.sv
// rtl/dmem_bus_arbiter.sv - two-master round-robin data-memory arbiter with lock, lock timeout and I/O decode
//
// Ports:
//   clk, rstn                     single rising-edge clock, asynchronous active-low reset
//   mN_req/we/addr/wdata/mask/lock master N (N=0 load/store unit, N=1 debug loader) request
//   mN_gnt                        combinational grant, same cycle as the request
//   mN_rvalid/rdata/rerr          registered response, one cycle after the grant
//   o_mem_*                       combinational strobes/address/data to d_mem
//   i_mem_read_data               d_mem combinational read data
//   io_write_addr/data/en         write-only I/O port for addresses at or above IO_BASE
module dmem_bus_arbiter #(
    parameter logic [31:0] IO_BASE      = 32'h8000_0000,
    parameter int unsigned MEM_SIZE     = 8196,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_mask,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_rerr,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_mask,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_rerr,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_write_data,
    output logic [1:0]  o_mem_data_mask,
    output logic        o_mem_write_en,
    output logic        o_mem_read_en,
    input  logic [31:0] i_mem_read_data,
    output logic [31:0] io_write_addr,
    output logic [31:0] io_write_data,
    output logic        io_write_en
);

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        LOCKED_M0 = 2'd1,
        LOCKED_M1 = 2'd2
    } lock_state_t;

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    lock_state_t      lock_state, lock_state_nxt;
    logic             prio, prio_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;

    logic             rsp_valid, rsp_err, rsp_to_m1;
    logic [31:0]      rsp_data;
    logic             rsp_valid_nxt, rsp_err_nxt;
    logic [31:0]      rsp_data_nxt;

    logic             any_gnt, sel_we, sel_lock, hit_mem, hit_io;
    logic [31:0]      sel_addr, sel_wdata;
    logic [1:0]       sel_mask;

    // Grants are qualified by rstn so every output reads 0 while reset is held,
    // even when a master keeps its request up.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rstn) begin
            case (lock_state)
                LOCKED_M0: m0_gnt = m0_req;
                LOCKED_M1: m1_gnt = m1_req;
                default: begin
                    if (m0_req && m1_req) begin
                        m0_gnt = !prio;
                        m1_gnt = prio;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
            endcase
        end
    end

    assign any_gnt   = m0_gnt | m1_gnt;
    assign sel_we    = m1_gnt ? m1_we    : m0_we;
    assign sel_lock  = m1_gnt ? m1_lock  : m0_lock;
    assign sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign sel_mask  = m1_gnt ? m1_mask  : m0_mask;

    assign hit_mem = any_gnt && (sel_addr < 32'(MEM_SIZE));
    assign hit_io  = any_gnt && (sel_addr >= IO_BASE);

    assign o_mem_write_en   = hit_mem && sel_we;
    assign o_mem_read_en    = hit_mem && !sel_we;
    assign o_mem_addr       = hit_mem ? sel_addr  : 32'd0;
    assign o_mem_write_data = hit_mem ? sel_wdata : 32'd0;
    assign o_mem_data_mask  = hit_mem ? sel_mask  : 2'd0;

    assign io_write_en   = hit_io && sel_we;
    assign io_write_addr = io_write_en ? sel_addr  : 32'd0;
    assign io_write_data = io_write_en ? sel_wdata : 32'd0;

    // Reads always answer; writes answer only when they fall in the decode hole.
    always_comb begin
        rsp_err_nxt   = any_gnt && !hit_mem && !hit_io;
        rsp_valid_nxt = any_gnt && (!sel_we || rsp_err_nxt);
        rsp_data_nxt  = o_mem_read_en ? i_mem_read_data : 32'd0;
    end

    always_comb begin
        lock_state_nxt = lock_state;
        lock_cnt_nxt   = lock_cnt;
        prio_nxt       = prio;
        if (any_gnt) begin
            // The master just served loses priority to the other one.
            prio_nxt     = m0_gnt;
            lock_cnt_nxt = '0;
            if (sel_lock) begin
                lock_state_nxt = m1_gnt ? LOCKED_M1 : LOCKED_M0;
            end else begin
                lock_state_nxt = UNLOCKED;
            end
        end else if (lock_state != UNLOCKED) begin
            // No grant while locked means the owner is idle.
            if (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                lock_state_nxt = UNLOCKED;
                lock_cnt_nxt   = '0;
            end else begin
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_state <= UNLOCKED;
            lock_cnt   <= '0;
            prio       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_to_m1  <= 1'b0;
            rsp_data   <= 32'd0;
        end else begin
            lock_state <= lock_state_nxt;
            lock_cnt   <= lock_cnt_nxt;
            prio       <= prio_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_err    <= rsp_err_nxt;
            rsp_to_m1  <= m1_gnt;
            rsp_data   <= rsp_data_nxt;
        end
    end

    assign m0_rvalid = rsp_valid && !rsp_to_m1;
    assign m1_rvalid = rsp_valid && rsp_to_m1;
    assign m0_rerr   = m0_rvalid && rsp_err;
    assign m1_rerr   = m1_rvalid && rsp_err;
    assign m0_rdata  = m0_rvalid ? rsp_data : 32'd0;
    assign m1_rdata  = m1_rvalid ? rsp_data : 32'd0;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb/tb_dmem_bus_arbiter.sv - self-checking bench for dmem_bus_arbiter against a transaction-level model
module tb_dmem_bus_arbiter;

    localparam logic [31:0] IO_BASE      = 32'h8000_0000;
    localparam logic [31:0] MEM_SIZE_B   = 32'd8196;
    localparam int          LOCK_TIMEOUT = 16;
    localparam int          MEM_WORDS    = 2049;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        m0_req = 0, m0_we = 0, m0_lock = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic [1:0]  m0_mask = 0;
    logic        m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic [1:0]  m1_mask = 0;
    logic        m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] o_mem_addr, o_mem_write_data, i_mem_read_data;
    logic [1:0]  o_mem_data_mask;
    logic        o_mem_write_en, o_mem_read_en;
    logic [31:0] io_write_addr, io_write_data;
    logic        io_write_en;

    dmem_bus_arbiter dut (
        .clk(clk), .rstn(rstn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_mask(m0_mask), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_mask(m1_mask), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
        .o_mem_addr(o_mem_addr), .o_mem_write_data(o_mem_write_data),
        .o_mem_data_mask(o_mem_data_mask), .o_mem_write_en(o_mem_write_en),
        .o_mem_read_en(o_mem_read_en), .i_mem_read_data(i_mem_read_data),
        .io_write_addr(io_write_addr), .io_write_data(io_write_data), .io_write_en(io_write_en)
    );

    // d_mem stand-in: combinational read, write at the clock edge.
    logic [31:0] dmem [MEM_WORDS];
    assign i_mem_read_data = dmem[o_mem_addr[13:2]];
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) dmem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        forever begin
            @(posedge clk);
            if (o_mem_write_en) dmem[o_mem_addr[13:2]] = o_mem_write_data;
        end
    end

    // Reference model: owner of the bus (-1 = nobody), preferred master,
    // idle cycles of the owner, a word store and the expected response.
    int          owner, pref, idle;
    logic [31:0] ref_mem [MEM_WORDS];
    bit   [1:0]  e_rv, e_re;
    logic [31:0] e_rd [2];
    int          last_win;
    logic        s_mem_we, s_mem_re, s_io_en, s_rv1, s_re1;
    logic [31:0] s_io_addr, s_io_data, s_rd1;
    logic [1:0]  s_mask;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; pref = 0; idle = 0;
        e_rv = 0; e_re = 0; e_rd[0] = 0; e_rd[1] = 0;
    endtask

    function automatic int model_winner();
        bit r0 = m0_req, r1 = m1_req;
        if (owner == 0) return r0 ? 0 : -1;
        if (owner == 1) return r1 ? 1 : -1;
        if (r0 && r1) return pref;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic issue(input int m, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] mk, input logic lk);
        if (m == 0) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_mask = mk; m0_lock = lk; end
        else        begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_mask = mk; m1_lock = lk; end
    endtask

    task automatic step();
        int win;
        logic we, lk, is_mem, is_io, is_err;
        logic [31:0] a, d;
        logic [1:0] mk;
        @(negedge clk);
        win = model_winner();
        if (win == 1) begin we = m1_we; a = m1_addr; d = m1_wdata; mk = m1_mask; lk = m1_lock; end
        else          begin we = m0_we; a = m0_addr; d = m0_wdata; mk = m0_mask; lk = m0_lock; end
        is_mem = (win >= 0) && (a < MEM_SIZE_B);
        is_io  = (win >= 0) && (a >= IO_BASE);
        is_err = (win >= 0) && !is_mem && !is_io;
        chk("gnt", {m1_gnt, m0_gnt}, {win == 1, win == 0});
        chk("mem_ctl", {o_mem_write_en, o_mem_read_en, o_mem_data_mask}, is_mem ? {we, !we, mk} : 4'b0);
        chk("mem_addr_data", {o_mem_addr, o_mem_write_data}, is_mem ? {a, d} : 64'b0);
        chk("io_en", io_write_en, is_io && we);
        chk("io_addr_data", {io_write_addr, io_write_data}, (is_io && we) ? {a, d} : 64'b0);
        chk("rsp0", {m0_rvalid, m0_rerr, m0_rdata}, {e_rv[0], e_re[0], e_rd[0]});
        chk("rsp1", {m1_rvalid, m1_rerr, m1_rdata}, {e_rv[1], e_re[1], e_rd[1]});
        s_mem_we = o_mem_write_en; s_mem_re = o_mem_read_en; s_mask = o_mem_data_mask;
        s_io_en = io_write_en; s_io_addr = io_write_addr; s_io_data = io_write_data;
        s_rv1 = m1_rvalid; s_re1 = m1_rerr; s_rd1 = m1_rdata;
        @(posedge clk);
        e_rv = 0; e_re = 0; e_rd[0] = 0; e_rd[1] = 0;
        if (win >= 0) begin
            if (!we || is_err) begin
                e_rv[win] = 1;
                e_re[win] = is_err;
                e_rd[win] = is_mem ? ref_mem[a[13:2]] : 32'd0;
            end
            if (is_mem && we) ref_mem[a[13:2]] = d;
            pref  = 1 - win;
            idle  = 0;
            owner = lk ? win : -1;
        end else if (owner >= 0) begin
            idle++;
            if (idle == LOCK_TIMEOUT) begin owner = -1; idle = 0; end
        end
        last_win = win;
        #1;
        if (win == 0) m0_req = 0;
        if (win == 1) m1_req = 0;
    endtask

    task automatic wait_gnt(input int m);
        int n = 0;
        do begin step(); n++; end while (last_win != m && n < 40);
        chk("wait_gnt", last_win, m);
    endtask

    task automatic drain();
        int n = 0;
        while ((m0_req || m1_req) && n < 40) begin step(); n++; end
        step();
    endtask

    task automatic rand_issue(input int m);
        int k = $urandom_range(0, 9);
        logic [31:0] a;
        case (k)
            0, 1, 2, 3, 4: a = $urandom_range(0, 31) * 4;
            5:             a = $urandom_range(0, 1) ? 32'd8192 : 32'd8195;
            6: case ($urandom_range(0, 2))
                   0:       a = MEM_SIZE_B;
                   1:       a = IO_BASE - 1;
                   default: a = $urandom_range(8196, 32'h7FFF_FFFF);
               endcase
            7, 8:          a = IO_BASE + $urandom_range(0, 255);
            default:       a = $urandom_range(0, 8195);
        endcase
        issue(m, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 2)),
              $urandom_range(0, 3) == 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
        model_reset();
        last_win = -1;
        m1_req = 1;
        #1;
        chk("reset_strobes", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr,
                              o_mem_write_en, o_mem_read_en, io_write_en}, 0);
        chk("reset_data", {m0_rdata, m1_rdata}, 0);
        chk("reset_addr", {o_mem_addr, io_write_addr}, 0);
        chk("reset_wdata", {o_mem_write_data, io_write_data, o_mem_data_mask}, 0);
        m1_req = 0;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1;

        // Both masters reading continuously: strict alternation starting with m0.
        for (int i = 0; i < 8; i++) begin
            if (!m0_req) issue(0, 0, 32'h10, 0, 2'b10, 0);
            if (!m1_req) issue(1, 0, 32'h20, 0, 2'b10, 0);
            step();
            chk("alternate", last_win, i % 2);
        end
        drain();

        // Write then read back from the other master.
        issue(0, 1, 32'h40, 32'hDEAD_BEEF, 2'b10, 0);
        wait_gnt(0);
        chk("wr_strobe_mask", {s_mem_we, s_mask}, 3'b110);
        issue(1, 0, 32'h40, 0, 2'b10, 0);
        wait_gnt(1);
        step();
        chk("rd_back", {s_rv1, s_rd1}, {1'b1, 32'hDEAD_BEEF});

        // I/O write.
        issue(0, 1, 32'h8000_0004, 32'h41, 2'b10, 0);
        wait_gnt(0);
        chk("io_write", {s_io_en, s_mem_we, s_io_addr, s_io_data}, {2'b10, 32'h8000_0004, 32'h41});
        step();
        chk("io_one_cycle", s_io_en, 1'b0);

        // Decode hole.
        issue(1, 0, 32'h0000_4000, 0, 2'b10, 0);
        wait_gnt(1);
        chk("err_nostrobe", {s_mem_we, s_mem_re, s_io_en}, 0);
        step();
        chk("err_rsp", {s_rv1, s_re1, s_rd1}, {2'b11, 32'd0});
        drain();

        // Lock held by m0 across three cycles, released by an unlocked write.
        issue(0, 0, 32'h10, 0, 2'b10, 1);
        step();
        chk("lock_gnt", last_win, 0);
        issue(1, 0, 32'h20, 0, 2'b10, 0);
        step();
        chk("locked_wait1", last_win, -1);
        step();
        chk("locked_wait2", last_win, -1);
        issue(0, 1, 32'h44, 32'h1234_5678, 2'b10, 0);
        step();
        chk("unlock_write", last_win, 0);
        step();
        chk("post_unlock", last_win, 1);
        drain();

        // Lock timeout.
        issue(0, 0, 32'h10, 0, 2'b10, 1);
        step();
        chk("to_lock_gnt", last_win, 0);
        issue(1, 0, 32'h24, 0, 2'b10, 0);
        n = 0;
        while (n < 40) begin
            step();
            if (last_win == 1) break;
            n++;
        end
        chk("timeout_cycles", n, LOCK_TIMEOUT);
        drain();

        // Asynchronous reset mid-lock with a response pending.
        issue(0, 0, 32'h10, 0, 2'b10, 1);
        step();
        issue(1, 0, 32'h28, 0, 2'b10, 0);
        chk("pre_reset_rvalid", m0_rvalid, 1'b1);
        #2 rstn = 0;
        #1;
        chk("midreset_strobes", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rerr, m1_rerr,
                                 o_mem_write_en, o_mem_read_en, io_write_en}, 0);
        chk("midreset_data", {m0_rdata, m1_rdata}, 0);
        chk("midreset_addr", {o_mem_addr, io_write_addr}, 0);
        model_reset();
        @(posedge clk); #1;
        rstn = 1;
        step();
        chk("post_reset_gnt", last_win, 1);
        drain();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (!m0_req && $urandom_range(0, 1) == 1) rand_issue(0);
            if (!m1_req && $urandom_range(0, 1) == 1) rand_issue(1);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
